// File: rtl/fetch_ctrl_if.sv
// Fetch-controller bus: ROM port, redirect/stall inputs from decode and the fetch-stage outputs.
// master = fetch controller, slave = the ROM/decode side that drives it.
interface fetch_ctrl_if #(
    parameter int ROM_AW = 10
);
    logic [ROM_AW-1:0] imem_addr;
    logic [31:0]       imem_rdata;
    logic              redir_valid;
    logic [1:0]        redir_kind;
    logic [31:0]       redir_target;
    logic              stall;
    logic              if_valid;
    logic [31:0]       if_instr;
    logic [31:0]       if_pc;
    logic [31:0]       if_pc_plus_4;
    logic              fault;
    logic [31:0]       perf_fetch;
    logic [31:0]       perf_bubble;

    modport master (
        output imem_addr,
        input  imem_rdata,
        input  redir_valid,
        input  redir_kind,
        input  redir_target,
        input  stall,
        output if_valid,
        output if_instr,
        output if_pc,
        output if_pc_plus_4,
        output fault,
        output perf_fetch,
        output perf_bubble
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        output redir_valid,
        output redir_kind,
        output redir_target,
        output stall,
        input  if_valid,
        input  if_instr,
        input  if_pc,
        input  if_pc_plus_4,
        input  fault,
        input  perf_fetch,
        input  perf_bubble
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Next-PC sequencer and fetch controller for a 1-cycle-latency instruction ROM.
// Optional perf counters enabled by defining FETCH_PERF_EN.
module fetch_ctrl #(
    parameter int          ROM_AW   = 10,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic          clk,
    input  logic          rst,
    fetch_ctrl_if.master  bus
);

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic        pend_valid_q, pend_valid_d;
    logic        fault_q, fault_d;
    logic        if_valid_s;
    logic        misalign_s;

    assign if_valid_s = pend_valid_q & (state_q == ST_RUN);
    assign misalign_s = (bus.redir_target[1:0] != 2'b00);

    // Next-state and next-PC selection
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_pc_d    = pend_pc_q;
        pend_valid_d = pend_valid_q;
        fault_d      = fault_q;
        case (state_q)
            ST_RESET: begin
                state_d      = ST_RUN;
                pend_pc_d    = pc_q;
                pend_valid_d = 1'b1;
                pc_d         = pc_q + 32'd4;
            end
            ST_RUN: begin
                if (bus.redir_valid && misalign_s) begin
                    state_d      = ST_FAULT;
                    fault_d      = 1'b1;
                    pend_valid_d = 1'b0;
                end else if (bus.redir_valid) begin
                    // Squashes any held instruction; the target is fetched on the next edge
                    pc_d         = bus.redir_target;
                    pend_valid_d = 1'b0;
                end else if (if_valid_s && bus.stall) begin
                    pc_d         = pc_q;
                end else begin
                    pend_pc_d    = pc_q;
                    pend_valid_d = 1'b1;
                    pc_d         = pc_q + 32'd4;
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d      = ST_RESET;
                pc_d         = RESET_PC;
                pend_pc_d    = RESET_PC;
                pend_valid_d = 1'b0;
                fault_d      = 1'b0;
            end
        endcase
    end

    // State and PC registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_RESET;
            pc_q         <= RESET_PC;
            pend_pc_q    <= RESET_PC;
            pend_valid_q <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_pc_q    <= pend_pc_d;
            pend_valid_q <= pend_valid_d;
            fault_q      <= fault_d;
        end
    end

    // While stalled the ROM re-reads the held PC so if_instr stays stable
    assign bus.imem_addr    = (if_valid_s && bus.stall) ? pend_pc_q[ROM_AW+1:2] : pc_q[ROM_AW+1:2];
    assign bus.if_valid     = if_valid_s;
    assign bus.if_instr     = bus.imem_rdata;
    assign bus.if_pc        = pend_pc_q;
    assign bus.if_pc_plus_4 = pend_pc_q + 32'd4;
    assign bus.fault        = fault_q;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_q, perf_fetch_d;
    logic [31:0] perf_bubble_q, perf_bubble_d;

    // Accepted-instruction and bubble counters
    always_comb begin
        perf_fetch_d  = perf_fetch_q;
        perf_bubble_d = perf_bubble_q;
        if (if_valid_s && !bus.stall) begin
            perf_fetch_d = perf_fetch_q + 32'd1;
        end else begin
            perf_fetch_d = perf_fetch_q;
        end
        if ((state_q == ST_RUN) && !if_valid_s) begin
            perf_bubble_d = perf_bubble_q + 32'd1;
        end else begin
            perf_bubble_d = perf_bubble_q;
        end
    end

    // Perf counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetch_q  <= 32'h0;
            perf_bubble_q <= 32'h0;
        end else begin
            perf_fetch_q  <= perf_fetch_d;
            perf_bubble_q <= perf_bubble_d;
        end
    end

    assign bus.perf_fetch  = perf_fetch_q;
    assign bus.perf_bubble = perf_bubble_q;
`else
    assign bus.perf_fetch  = 32'h0;
    assign bus.perf_bubble = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a ROM model where ROM[i] = i.
module tb_fetch_ctrl;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_miss;

`ifdef FETCH_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    fetch_ctrl_if #(.ROM_AW(10)) bus ();

    fetch_ctrl #(.ROM_AW(10), .RESET_PC(32'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM: one-cycle synchronous read, word i holds value i
    always @(posedge clk) bus.imem_rdata <= {22'd0, bus.imem_addr};

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_vec++; if (bus.if_valid !== 1'b0) begin n_miss++; $display("FAIL rst_valid: got %b expected 0", bus.if_valid); end
        n_vec++; if (bus.fault !== 1'b0) begin n_miss++; $display("FAIL rst_fault: got %b expected 0", bus.fault); end
        n_vec++; if (bus.perf_fetch !== 32'h0) begin n_miss++; $display("FAIL rst_perf_fetch: got %h expected 0", bus.perf_fetch); end
        n_vec++; if (bus.imem_addr !== 10'd0) begin n_miss++; $display("FAIL rst_addr: got %h expected 0", bus.imem_addr); end
        rst = 1'b1;
    endtask

    task automatic test_free_run();
        @(negedge clk);
        n_vec++; if (bus.if_valid !== 1'b1) begin n_miss++; $display("FAIL t1_valid: got %b expected 1", bus.if_valid); end
        n_vec++; if (bus.if_pc !== 32'h0) begin n_miss++; $display("FAIL t1_pc0: got %h expected 0", bus.if_pc); end
        n_vec++; if (bus.if_instr !== 32'h0) begin n_miss++; $display("FAIL t1_instr0: got %h expected 0", bus.if_instr); end
        @(negedge clk);
        n_vec++; if (bus.if_pc !== 32'h4) begin n_miss++; $display("FAIL t1_pc4: got %h expected 4", bus.if_pc); end
        n_vec++; if (bus.if_instr !== 32'h1) begin n_miss++; $display("FAIL t1_instr1: got %h expected 1", bus.if_instr); end
        n_vec++; if (bus.if_pc_plus_4 !== 32'h8) begin n_miss++; $display("FAIL t1_pc_plus_4: got %h expected 8", bus.if_pc_plus_4); end
        @(negedge clk);
        n_vec++; if (bus.if_pc !== 32'h8) begin n_miss++; $display("FAIL t1_pc8: got %h expected 8", bus.if_pc); end
    endtask

    task automatic test_stall();
        bus.stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_vec++; if (bus.if_valid !== 1'b1) begin n_miss++; $display("FAIL t2_valid[%0d]: got %b expected 1", k, bus.if_valid); end
            n_vec++; if (bus.if_pc !== 32'h8) begin n_miss++; $display("FAIL t2_pc[%0d]: got %h expected 8", k, bus.if_pc); end
            n_vec++; if (bus.if_instr !== 32'h2) begin n_miss++; $display("FAIL t2_instr[%0d]: got %h expected 2", k, bus.if_instr); end
            n_vec++; if (bus.imem_addr !== 10'd2) begin n_miss++; $display("FAIL t2_addr[%0d]: got %h expected 2", k, bus.imem_addr); end
        end
        bus.stall = 1'b0;
        @(negedge clk);
        n_vec++; if (bus.if_pc !== 32'hC) begin n_miss++; $display("FAIL t2_pc_after: got %h expected c", bus.if_pc); end
        n_vec++; if (bus.if_instr !== 32'h3) begin n_miss++; $display("FAIL t2_instr_after: got %h expected 3", bus.if_instr); end
    endtask

    task automatic test_redirect();
        bus.redir_valid  = 1'b1;
        bus.redir_kind   = 2'b01;
        bus.redir_target = 32'h40;
        @(negedge clk);
        bus.redir_valid = 1'b0;
        n_vec++; if (bus.if_valid !== 1'b0) begin n_miss++; $display("FAIL t3_bubble: got %b expected 0", bus.if_valid); end
        @(negedge clk);
        n_vec++; if (bus.if_valid !== 1'b1) begin n_miss++; $display("FAIL t3_valid: got %b expected 1", bus.if_valid); end
        n_vec++; if (bus.if_pc !== 32'h40) begin n_miss++; $display("FAIL t3_pc: got %h expected 40", bus.if_pc); end
        n_vec++; if (bus.if_instr !== 32'd16) begin n_miss++; $display("FAIL t3_instr: got %h expected 10", bus.if_instr); end
        n_vec++; if (bus.if_pc_plus_4 !== 32'h44) begin n_miss++; $display("FAIL t3_pc_plus_4: got %h expected 44", bus.if_pc_plus_4); end
    endtask

    task automatic test_back_to_back_redirect_stall();
        bus.stall        = 1'b1;
        bus.redir_valid  = 1'b1;
        bus.redir_kind   = 2'b00;
        bus.redir_target = 32'h80;
        @(negedge clk);
        bus.stall       = 1'b0;
        bus.redir_valid = 1'b0;
        n_vec++; if (bus.if_valid !== 1'b0) begin n_miss++; $display("FAIL t4_bubble: got %b expected 0", bus.if_valid); end
        @(negedge clk);
        n_vec++; if (bus.if_pc !== 32'h80) begin n_miss++; $display("FAIL t4_pc: got %h expected 80", bus.if_pc); end
        n_vec++; if (bus.if_instr !== 32'd32) begin n_miss++; $display("FAIL t4_instr: got %h expected 20", bus.if_instr); end
        chk("t4_perf_fetch", bus.perf_fetch, PERF ? 32'd4 : 32'd0);
        chk("t4_perf_bubble", bus.perf_bubble, PERF ? 32'd2 : 32'd0);
    endtask

    task automatic test_fault();
        bus.redir_valid  = 1'b1;
        bus.redir_kind   = 2'b10;
        bus.redir_target = 32'h42;
        @(negedge clk);
        n_vec++; if (bus.fault !== 1'b1) begin n_miss++; $display("FAIL t5_fault: got %b expected 1", bus.fault); end
        n_vec++; if (bus.if_valid !== 1'b0) begin n_miss++; $display("FAIL t5_valid: got %b expected 0", bus.if_valid); end
        bus.redir_target = 32'h100;
        bus.stall        = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_vec++; if (bus.fault !== 1'b1) begin n_miss++; $display("FAIL t5_sticky[%0d]: got %b expected 1", k, bus.fault); end
            n_vec++; if (bus.if_valid !== 1'b0) begin n_miss++; $display("FAIL t5_hold_valid[%0d]: got %b expected 0", k, bus.if_valid); end
            n_vec++; if (bus.imem_addr !== 10'h21) begin n_miss++; $display("FAIL t5_frozen_addr[%0d]: got %h expected 21", k, bus.imem_addr); end
        end
        bus.redir_valid = 1'b0;
        bus.stall       = 1'b0;
        rst = 1'b0;
        #1;
        n_vec++; if (bus.fault !== 1'b0) begin n_miss++; $display("FAIL t5_rst_fault: got %b expected 0", bus.fault); end
        n_vec++; if (bus.imem_addr !== 10'd0) begin n_miss++; $display("FAIL t5_rst_addr: got %h expected 0", bus.imem_addr); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_vec++; if (bus.if_valid !== 1'b1) begin n_miss++; $display("FAIL t5_restart_valid: got %b expected 1", bus.if_valid); end
        n_vec++; if (bus.if_pc !== 32'h0) begin n_miss++; $display("FAIL t5_restart_pc: got %h expected 0", bus.if_pc); end
    endtask

    task automatic test_midrun_reset_wrap();
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        n_vec++; if (bus.if_valid !== 1'b0) begin n_miss++; $display("FAIL t6_async_valid: got %b expected 0", bus.if_valid); end
        n_vec++; if (bus.perf_fetch !== 32'h0) begin n_miss++; $display("FAIL t6_perf_fetch: got %h expected 0", bus.perf_fetch); end
        n_vec++; if (bus.perf_bubble !== 32'h0) begin n_miss++; $display("FAIL t6_perf_bubble: got %h expected 0", bus.perf_bubble); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_vec++; if (bus.if_pc !== 32'h0) begin n_miss++; $display("FAIL t6_restart_pc: got %h expected 0", bus.if_pc); end
        bus.redir_valid  = 1'b1;
        bus.redir_kind   = 2'b11;
        bus.redir_target = 32'hFFFF_FFFC;
        @(negedge clk);
        bus.redir_valid = 1'b0;
        @(negedge clk);
        n_vec++; if (bus.if_pc !== 32'hFFFF_FFFC) begin n_miss++; $display("FAIL t6_top_pc: got %h expected fffffffc", bus.if_pc); end
        n_vec++; if (bus.if_instr !== 32'd1023) begin n_miss++; $display("FAIL t6_top_instr: got %h expected 3ff", bus.if_instr); end
        n_vec++; if (bus.if_pc_plus_4 !== 32'h0) begin n_miss++; $display("FAIL t6_top_plus4: got %h expected 0", bus.if_pc_plus_4); end
        @(negedge clk);
        n_vec++; if (bus.if_pc !== 32'h0) begin n_miss++; $display("FAIL t6_wrap_pc: got %h expected 0", bus.if_pc); end
        n_vec++; if (bus.if_instr !== 32'h0) begin n_miss++; $display("FAIL t6_wrap_instr: got %h expected 0", bus.if_instr); end
        n_vec++; if (bus.if_pc_plus_4 !== 32'h4) begin n_miss++; $display("FAIL t6_wrap_plus4: got %h expected 4", bus.if_pc_plus_4); end
    endtask

    initial begin
        n_vec            = 0;
        n_miss           = 0;
        rst              = 1'b0;
        bus.redir_valid  = 1'b0;
        bus.redir_kind   = 2'b00;
        bus.redir_target = 32'h0;
        bus.stall        = 1'b0;
        test_reset();
        test_free_run();
        test_stall();
        test_redirect();
        test_back_to_back_redirect_stall();
        test_fault();
        test_midrun_reset_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
